// File: rtl/exu_mem_arb_if.sv
// ICB-style command/response bundle shared by the IFU, LSU and memory sides of exu_mem_arb.
// master drives commands and accepts responses; slave accepts commands and returns responses.
interface exu_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_read;
    logic [XLEN-1:0]     cmd_wdata;
    logic [XLEN/8-1:0]   cmd_wmask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/exu_mem_arb.sv
// Shares one memory ICB port between IFU fetches and LSU loads/stores, routing in-order responses back.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module exu_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int XLEN       = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    exu_mem_arb_if.slave        ifu_icb,
    exu_mem_arb_if.slave        lsu_icb,
    exu_mem_arb_if.master       mem_icb,
    output logic                arb_err
);

    localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;
    localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic ID_IFU = 1'b0;
    localparam logic ID_LSU = 1'b1;

    typedef enum logic {
        LK_OPEN,
        LK_HELD
    } lock_e;

    lock_e             r_lockState;
    lock_e             w_lockNext;
    logic              r_lockId;
    logic              w_lockIdNext;

    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic              r_idFifo [OUTS_DEPTH];

    logic              w_grant;
    logic              w_reqValid;
    logic              w_full;
    logic              w_hasOut;
    logic              w_head;
    logic              w_memCmdValid;
    logic              w_cmdAccept;
    logic              w_cmdFire;
    logic              w_memRspReady;
    logic              w_rspFire;
    logic              w_stray;

`ifdef MEM_ARB_RR_EN
    logic              r_rrLast;
`endif

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_cnt == CNT_W'(OUTS_DEPTH));
    assign w_hasOut = (r_cnt != '0);
    assign w_head   = r_idFifo[r_rdPtr];

    // A held (locked) command keeps its grant until it handshakes, so its fields stay stable.
    always_comb begin
        w_grant = ID_IFU;
        if (r_lockState == LK_HELD) begin
            w_grant = r_lockId;
        end else if (ifu_icb.cmd_valid && lsu_icb.cmd_valid) begin
`ifdef MEM_ARB_RR_EN
            w_grant = ~r_rrLast;
`else
            w_grant = ID_LSU;
`endif
        end else if (lsu_icb.cmd_valid) begin
            w_grant = ID_LSU;
        end
    end

    assign w_reqValid    = (w_grant == ID_LSU) ? lsu_icb.cmd_valid : ifu_icb.cmd_valid;
    assign w_memCmdValid = !rst && w_reqValid && !w_full;
    assign w_cmdAccept   = !rst && mem_icb.cmd_ready && !w_full;
    assign w_cmdFire     = w_memCmdValid && mem_icb.cmd_ready;

    assign mem_icb.cmd_valid = w_memCmdValid;
    assign mem_icb.cmd_addr  = (w_grant == ID_LSU) ? lsu_icb.cmd_addr  : ifu_icb.cmd_addr;
    assign mem_icb.cmd_read  = (w_grant == ID_LSU) ? lsu_icb.cmd_read  : 1'b1;
    assign mem_icb.cmd_wdata = (w_grant == ID_LSU) ? lsu_icb.cmd_wdata : '0;
    assign mem_icb.cmd_wmask = (w_grant == ID_LSU) ? lsu_icb.cmd_wmask : '0;

    assign ifu_icb.cmd_ready = w_cmdAccept && (w_grant == ID_IFU);
    assign lsu_icb.cmd_ready = w_cmdAccept && (w_grant == ID_LSU);

    // With nothing outstanding the memory side is always drained so a stray response cannot stall it.
    assign w_memRspReady = !rst && (!w_hasOut ||
                           ((w_head == ID_LSU) ? lsu_icb.rsp_ready : ifu_icb.rsp_ready));
    assign w_rspFire     = w_hasOut && mem_icb.rsp_valid && w_memRspReady;
    assign w_stray       = !rst && !w_hasOut && mem_icb.rsp_valid;

    assign mem_icb.rsp_ready = w_memRspReady;
    assign ifu_icb.rsp_valid = !rst && w_hasOut && (w_head == ID_IFU) && mem_icb.rsp_valid;
    assign lsu_icb.rsp_valid = !rst && w_hasOut && (w_head == ID_LSU) && mem_icb.rsp_valid;
    assign ifu_icb.rsp_rdata = mem_icb.rsp_rdata;
    assign lsu_icb.rsp_rdata = mem_icb.rsp_rdata;

    always_comb begin
        w_lockNext   = r_lockState;
        w_lockIdNext = r_lockId;
        case (r_lockState)
            LK_OPEN: begin
                if (w_memCmdValid && !mem_icb.cmd_ready) begin
                    w_lockNext   = LK_HELD;
                    w_lockIdNext = w_grant;
                end
            end
            LK_HELD: begin
                if (w_cmdFire) begin
                    w_lockNext = LK_OPEN;
                end
            end
            default: w_lockNext = LK_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockState <= LK_OPEN;
            r_lockId    <= ID_IFU;
        end else begin
            r_lockState <= w_lockNext;
            r_lockId    <= w_lockIdNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_cmdFire) begin
                r_wrPtr <= ptrInc(r_wrPtr);
            end
            if (w_rspFire) begin
                r_rdPtr <= ptrInc(r_rdPtr);
            end
            if (w_cmdFire && !w_rspFire) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_cmdFire && w_rspFire) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read while counted as outstanding.
    always_ff @(posedge clk) begin
        if (!rst && w_cmdFire) begin
            r_idFifo[r_wrPtr] <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if (w_stray) begin
            arb_err <= 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrLast <= ID_IFU;
        end else if (w_cmdFire) begin
            r_rrLast <= w_grant;
        end
    end
`endif

endmodule

// File: tb/tb_exu_mem_arb.sv
// Directed, table-driven bench for exu_mem_arb; follows MEM_ARB_RR_EN for the arbitration expectations.
module tb_exu_mem_arb;

    logic clk;
    logic rst;
    logic arbErr;

    exu_mem_arb_if #(.ADDR_W(32), .XLEN(32)) ifuBus ();
    exu_mem_arb_if #(.ADDR_W(32), .XLEN(32)) lsuBus ();
    exu_mem_arb_if #(.ADDR_W(32), .XLEN(32)) memBus ();

    exu_mem_arb #(.ADDR_W(32), .XLEN(32), .OUTS_DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ifu_icb (ifuBus.slave),
        .lsu_icb (lsuBus.slave),
        .mem_icb (memBus.master),
        .arb_err (arbErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifuV;
        logic [31:0] ifuAddr;
        logic        lsuV;
        logic [31:0] lsuAddr;
        logic        lsuRead;
        logic [31:0] lsuWdata;
        logic [3:0]  lsuWmask;
        logic        memCmdRdy;
        logic        memRspV;
        logic [31:0] memRspData;
        logic        ifuRspRdy;
        logic        lsuRspRdy;
        logic        eMemCmdV;
        logic [31:0] eMemAddr;
        logic        eMemRead;
        logic [31:0] eMemWdata;
        logic [3:0]  eMemWmask;
        logic        eIfuCmdRdy;
        logic        eLsuCmdRdy;
        logic        eIfuRspV;
        logic        eLsuRspV;
        logic        eMemRspRdy;
        logic        eArbErr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t idleVec();
        vec_t v;
        v.rst = 1'b0;  v.ifuV = 1'b0;  v.ifuAddr = 32'h0;
        v.lsuV = 1'b0; v.lsuAddr = 32'h0; v.lsuRead = 1'b1;
        v.lsuWdata = 32'h0; v.lsuWmask = 4'h0;
        v.memCmdRdy = 1'b0; v.memRspV = 1'b0; v.memRspData = 32'h0;
        v.ifuRspRdy = 1'b1; v.lsuRspRdy = 1'b1;
        v.eMemCmdV = 1'b0; v.eMemAddr = 32'h0; v.eMemRead = 1'b1;
        v.eMemWdata = 32'h0; v.eMemWmask = 4'h0;
        v.eIfuCmdRdy = 1'b0; v.eLsuCmdRdy = 1'b0;
        v.eIfuRspV = 1'b0; v.eLsuRspV = 1'b0;
        v.eMemRspRdy = 1'b1; v.eArbErr = 1'b0;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst              = v.rst;
        ifuBus.cmd_valid = v.ifuV;
        ifuBus.cmd_addr  = v.ifuAddr;
        ifuBus.cmd_read  = 1'b1;
        ifuBus.cmd_wdata = 32'h0;
        ifuBus.cmd_wmask = 4'h0;
        ifuBus.rsp_ready = v.ifuRspRdy;
        lsuBus.cmd_valid = v.lsuV;
        lsuBus.cmd_addr  = v.lsuAddr;
        lsuBus.cmd_read  = v.lsuRead;
        lsuBus.cmd_wdata = v.lsuWdata;
        lsuBus.cmd_wmask = v.lsuWmask;
        lsuBus.rsp_ready = v.lsuRspRdy;
        memBus.cmd_ready = v.memCmdRdy;
        memBus.rsp_valid = v.memRspV;
        memBus.rsp_rdata = v.memRspData;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkBit({tag, ".arbErr"},    arbErr,           v.eArbErr);
        checkBit({tag, ".memCmdV"},   memBus.cmd_valid, v.eMemCmdV);
        checkBit({tag, ".ifuCmdRdy"}, ifuBus.cmd_ready, v.eIfuCmdRdy);
        checkBit({tag, ".lsuCmdRdy"}, lsuBus.cmd_ready, v.eLsuCmdRdy);
        checkBit({tag, ".ifuRspV"},   ifuBus.rsp_valid, v.eIfuRspV);
        checkBit({tag, ".lsuRspV"},   lsuBus.rsp_valid, v.eLsuRspV);
        checkBit({tag, ".memRspRdy"}, memBus.rsp_ready, v.eMemRspRdy);
        if (v.eMemCmdV) begin
            checkWord({tag, ".memAddr"},  memBus.cmd_addr,  v.eMemAddr);
            checkBit ({tag, ".memRead"},  memBus.cmd_read,  v.eMemRead);
            checkWord({tag, ".memWdata"}, memBus.cmd_wdata, v.eMemWdata);
            checkWord({tag, ".memWmask"}, {28'h0, memBus.cmd_wmask}, {28'h0, v.eMemWmask});
        end
        if (v.eIfuRspV) checkWord({tag, ".ifuRdata"}, ifuBus.rsp_rdata, v.memRspData);
        if (v.eLsuRspV) checkWord({tag, ".lsuRdata"}, lsuBus.rsp_rdata, v.memRspData);
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic stepVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;
    logic expLsu [4];
    logic prevG;

    initial begin
        // Reset, then single IFU fetch and response.
        v = idleVec(); v.rst = 1'b1; v.ifuV = 1'b1; v.memCmdRdy = 1'b1; v.memRspV = 1'b1;
        v.eMemRspRdy = 1'b0; tbl.push_back(v);
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h8000_0000; v.memCmdRdy = 1'b1;
        v.lsuWdata = 32'hCAFE_F00D; v.lsuWmask = 4'hF;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h8000_0000; v.eIfuCmdRdy = 1'b1; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h0000_0513; v.eIfuRspV = 1'b1; tbl.push_back(v);
        // IFU then LSU command, in-order responses, LSU back-pressure.
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h100; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h100; v.eIfuCmdRdy = 1'b1; tbl.push_back(v);
        v = idleVec(); v.lsuV = 1'b1; v.lsuAddr = 32'h200; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h200; v.eLsuCmdRdy = 1'b1; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h11; v.eIfuRspV = 1'b1; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h22; v.lsuRspRdy = 1'b0;
        v.eLsuRspV = 1'b1; v.eMemRspRdy = 1'b0; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h22; v.eLsuRspV = 1'b1; tbl.push_back(v);
        // FIFO full blocks a third command, even on a pop cycle.
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h300; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h300; v.eIfuCmdRdy = 1'b1; tbl.push_back(v);
        v.ifuAddr = 32'h304; v.eMemAddr = 32'h304; tbl.push_back(v);
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h308; v.memCmdRdy = 1'b1; tbl.push_back(v);
        v.memRspV = 1'b1; v.memRspData = 32'h33; v.eIfuRspV = 1'b1; tbl.push_back(v);
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h308; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h308; v.eIfuCmdRdy = 1'b1; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h44; v.eIfuRspV = 1'b1; tbl.push_back(v);
        v.memRspData = 32'h55; tbl.push_back(v);
        // Stray response with nothing outstanding; arb_err sticks until reset.
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h66; tbl.push_back(v);
        v = idleVec(); v.eArbErr = 1'b1; tbl.push_back(v);
        v = idleVec(); v.rst = 1'b1; v.eMemRspRdy = 1'b0; v.eArbErr = 1'b1; tbl.push_back(v);
        v = idleVec(); tbl.push_back(v);
        // Reset with one command outstanding, then a late response.
        v = idleVec(); v.ifuV = 1'b1; v.ifuAddr = 32'h800; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h800; v.eIfuCmdRdy = 1'b1; tbl.push_back(v);
        v = idleVec(); v.rst = 1'b1; v.eMemRspRdy = 1'b0; tbl.push_back(v);
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h77; tbl.push_back(v);
        v = idleVec(); v.eArbErr = 1'b1; tbl.push_back(v);

        applyStimulus(idleVec());
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            stepVec(tbl[i], $sformatf("vec%0d", i));
        end

        // Both requesters continuously valid for four grants.
        v = idleVec(); v.rst = 1'b1; v.eMemRspRdy = 1'b0; v.eArbErr = 1'b1;
        stepVec(v, "arb.rst");
`ifdef MEM_ARB_RR_EN
        expLsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        expLsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        prevG = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = idleVec();
            v.ifuV = 1'b1; v.ifuAddr = 32'h400;
            v.lsuV = 1'b1; v.lsuAddr = 32'h500;
            v.memCmdRdy = 1'b1;
            v.memRspV = (k > 0); v.memRspData = 32'h1000 + k;
            v.eMemCmdV = 1'b1;
            v.eMemAddr = expLsu[k] ? 32'h500 : 32'h400;
            v.eLsuCmdRdy = expLsu[k];
            v.eIfuCmdRdy = !expLsu[k];
            v.eIfuRspV = (k > 0) && !prevG;
            v.eLsuRspV = (k > 0) && prevG;
            stepVec(v, $sformatf("arb%0d", k));
            prevG = expLsu[k];
        end
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h2000;
        v.eIfuRspV = !prevG; v.eLsuRspV = prevG;
        stepVec(v, "arb.drain");

        // Store stalled by memory while IFU also requests: LSU fields stay locked.
        for (int k = 0; k < 4; k++) begin
            v = idleVec();
            v.ifuV = 1'b1; v.ifuAddr = 32'h600;
            v.lsuV = 1'b1; v.lsuAddr = 32'h8000_0010; v.lsuRead = 1'b0;
            v.lsuWdata = 32'hDEAD_BEEF; v.lsuWmask = 4'hF;
            v.memCmdRdy = (k == 3);
            v.eMemCmdV = 1'b1; v.eMemAddr = 32'h8000_0010; v.eMemRead = 1'b0;
            v.eMemWdata = 32'hDEAD_BEEF; v.eMemWmask = 4'hF;
            v.eLsuCmdRdy = (k == 3);
            stepVec(v, $sformatf("store%0d", k));
        end
        v = idleVec();
        v.ifuV = 1'b1; v.ifuAddr = 32'h600;
        v.lsuAddr = 32'h8000_0010; v.lsuRead = 1'b0; v.lsuWdata = 32'hDEAD_BEEF; v.lsuWmask = 4'hF;
        v.memCmdRdy = 1'b1; v.memRspV = 1'b1; v.memRspData = 32'h88;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h600; v.eIfuCmdRdy = 1'b1; v.eLsuRspV = 1'b1;
        stepVec(v, "store.ifu");
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'h99; v.eIfuRspV = 1'b1;
        stepVec(v, "store.rsp");

        // Stalled IFU fetch keeps its grant when the LSU arrives.
        for (int k = 0; k < 3; k++) begin
            v = idleVec();
            v.ifuV = 1'b1; v.ifuAddr = 32'h700;
            v.lsuV = (k > 0); v.lsuAddr = 32'h704;
            v.memCmdRdy = (k == 2);
            v.eMemCmdV = 1'b1; v.eMemAddr = 32'h700;
            v.eIfuCmdRdy = (k == 2);
            stepVec(v, $sformatf("ifuLock%0d", k));
        end
        v = idleVec(); v.lsuV = 1'b1; v.lsuAddr = 32'h704; v.memCmdRdy = 1'b1;
        v.eMemCmdV = 1'b1; v.eMemAddr = 32'h704; v.eLsuCmdRdy = 1'b1;
        stepVec(v, "ifuLock.lsu");
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'hAA; v.eIfuRspV = 1'b1;
        stepVec(v, "ifuLock.rsp0");
        v = idleVec(); v.memRspV = 1'b1; v.memRspData = 32'hBB; v.eLsuRspV = 1'b1;
        stepVec(v, "ifuLock.rsp1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
